// File: rtl/ldpc_pkg.sv
// Shared LDPC frame constants and state encodings for the encoder and the frame unpacker.
// The 18-bit word, 1440 info words and 2160 parity words describe one 64800-bit normal FEC frame.
package ldpc_pkg;

    localparam int WORD_WIDTH    = 18;
    localparam int IN_WIDTH      = 19;
    localparam int INFO_WORDS    = 1440;
    localparam int PARITY_WORDS  = 2160;
    localparam int FRAME_WORDS   = INFO_WORDS + PARITY_WORDS;
    localparam int ADDR_WIDTH    = 12;
    localparam int BIT_IDX_WIDTH = 5;

    localparam logic [ADDR_WIDTH-1:0]    LAST_WORD    = ADDR_WIDTH'(FRAME_WORDS - 1);
    localparam logic [ADDR_WIDTH-1:0]    PARITY_START = ADDR_WIDTH'(INFO_WORDS);
    localparam logic [BIT_IDX_WIDTH-1:0] LAST_BIT     = BIT_IDX_WIDTH'(WORD_WIDTH - 1);

    typedef enum logic [1:0] {
        W_IDLE,
        W_FILL,
        W_HOLD,
        W_WAIT
    } wr_state_t;

    typedef enum logic [1:0] {
        R_IDLE,
        R_FETCH,
        R_SHIFT
    } rd_state_t;

endpackage

// File: rtl/ram_1r1w.sv
// Simple dual-port word RAM: one write port, one read port with a registered read
// (data appears the cycle after rd_en). No reset on the storage array.
module ram_1r1w #(
    parameter int DATA_WIDTH = 18,
    parameter int ADDR_WIDTH = 12,
    parameter int DEPTH      = 3600
) (
    input  logic                  clk,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/ldpc_frame_unpacker.sv
// Buffers one LDPC codeword (3600 x 18-bit words) and replays it as a backpressured
// bit-serial stream tagged with sof/eof/is_parity; a write FSM and a read FSM share one RAM.
module ldpc_frame_unpacker
    import ldpc_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic                valid_in,
    input  logic [IN_WIDTH-1:0] data_in,
    input  logic                bit_ready,
    output logic                bit_valid,
    output logic                bit_out,
    output logic                sof,
    output logic                eof,
    output logic                is_parity,
    output logic                frame_done,
    output logic                overflow
);

    wr_state_t               wr_state, wr_state_nxt;
    logic [ADDR_WIDTH-1:0]   wr_cnt, wr_cnt_nxt;
    logic                    drained, drained_nxt;
    logic                    overflow_nxt;
    logic                    ram_we;

    rd_state_t               rd_state, rd_state_nxt;
    logic [ADDR_WIDTH-1:0]   rd_word, rd_word_nxt;
    logic [ADDR_WIDTH-1:0]   next_word;
    logic [ADDR_WIDTH-1:0]   rd_addr;
    logic [BIT_IDX_WIDTH-1:0] bit_idx, bit_idx_nxt;
    logic [WORD_WIDTH-1:0]   shreg, shreg_nxt;
    logic [WORD_WIDTH-1:0]   ram_q;
    logic                    rd_pend, rd_pend_nxt;
    logic                    ram_re;
    logic                    accept;
    logic                    word_end;
    logic                    rd_complete;

    // The spare tag bit on the encoder bus carries no frame payload.
    logic unused_tag_bit;
    assign unused_tag_bit = data_in[WORD_WIDTH];

    ram_1r1w #(
        .DATA_WIDTH(WORD_WIDTH),
        .ADDR_WIDTH(ADDR_WIDTH),
        .DEPTH     (FRAME_WORDS)
    ) u_frame_buf (
        .clk    (clk),
        .wr_en  (ram_we),
        .wr_addr(wr_cnt),
        .wr_data(data_in[WORD_WIDTH-1:0]),
        .rd_en  (ram_re),
        .rd_addr(rd_addr),
        .rd_data(ram_q)
    );

    assign accept      = (rd_state == R_SHIFT) && bit_ready;
    assign word_end    = accept && (bit_idx == LAST_BIT);
    assign rd_complete = word_end && (rd_word == LAST_WORD);
    assign next_word   = rd_word + ADDR_WIDTH'(1);

    // Write side. 'drained' remembers a read completion that lands while the source is
    // still streaming in W_HOLD, so leaving HOLD can go straight back to W_IDLE.
    always_comb begin
        wr_state_nxt = wr_state;
        wr_cnt_nxt   = wr_cnt;
        drained_nxt  = drained;
        overflow_nxt = overflow;
        ram_we       = 1'b0;
        case (wr_state)
            W_IDLE: begin
                drained_nxt = 1'b0;
                if (valid_in) begin
                    ram_we       = 1'b1;
                    wr_cnt_nxt   = wr_cnt + ADDR_WIDTH'(1);
                    wr_state_nxt = W_FILL;
                end
            end
            W_FILL: begin
                if (valid_in) begin
                    ram_we     = 1'b1;
                    wr_cnt_nxt = wr_cnt + ADDR_WIDTH'(1);
                    if (wr_cnt == LAST_WORD) begin
                        wr_state_nxt = W_HOLD;
                    end
                end
            end
            W_HOLD: begin
                if (rd_complete) begin
                    drained_nxt = 1'b1;
                    wr_cnt_nxt  = '0;
                end
                if (!valid_in) begin
                    wr_state_nxt = (drained || rd_complete) ? W_IDLE : W_WAIT;
                end
            end
            W_WAIT: begin
                if (rd_complete) begin
                    wr_cnt_nxt   = '0;
                    wr_state_nxt = W_IDLE;
                    if (valid_in) begin
                        overflow_nxt = 1'b1;
                    end
                end else if (valid_in) begin
                    overflow_nxt = 1'b1;
                    wr_state_nxt = W_HOLD;
                end
            end
            default: wr_state_nxt = W_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_state <= W_IDLE;
            wr_cnt   <= '0;
            drained  <= 1'b0;
            overflow <= 1'b0;
        end else begin
            wr_state <= wr_state_nxt;
            wr_cnt   <= wr_cnt_nxt;
            drained  <= drained_nxt;
            overflow <= overflow_nxt;
        end
    end

    // Read side. The next word is prefetched on the acceptance of bit 17, which leaves
    // exactly one bubble cycle (the R_FETCH load) between consecutive words.
    always_comb begin
        rd_state_nxt = rd_state;
        rd_word_nxt  = rd_word;
        bit_idx_nxt  = bit_idx;
        shreg_nxt    = shreg;
        rd_pend_nxt  = 1'b0;
        ram_re       = 1'b0;
        rd_addr      = rd_word;
        case (rd_state)
            R_IDLE: begin
                if (rd_word < wr_cnt) begin
                    ram_re       = 1'b1;
                    rd_pend_nxt  = 1'b1;
                    rd_state_nxt = R_FETCH;
                end
            end
            R_FETCH: begin
                if (rd_pend) begin
                    shreg_nxt    = ram_q;
                    bit_idx_nxt  = '0;
                    rd_state_nxt = R_SHIFT;
                end else if (rd_word < wr_cnt) begin
                    ram_re      = 1'b1;
                    rd_pend_nxt = 1'b1;
                end
            end
            R_SHIFT: begin
                if (accept) begin
                    shreg_nxt   = {1'b0, shreg[WORD_WIDTH-1:1]};
                    bit_idx_nxt = bit_idx + BIT_IDX_WIDTH'(1);
                    if (word_end) begin
                        bit_idx_nxt = '0;
                        if (rd_complete) begin
                            rd_word_nxt  = '0;
                            rd_state_nxt = R_IDLE;
                        end else begin
                            rd_word_nxt  = next_word;
                            rd_addr      = next_word;
                            rd_state_nxt = R_FETCH;
                            if (next_word < wr_cnt) begin
                                ram_re      = 1'b1;
                                rd_pend_nxt = 1'b1;
                            end
                        end
                    end
                end
            end
            default: rd_state_nxt = R_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_state   <= R_IDLE;
            rd_word    <= '0;
            bit_idx    <= '0;
            shreg      <= '0;
            rd_pend    <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            rd_state   <= rd_state_nxt;
            rd_word    <= rd_word_nxt;
            bit_idx    <= bit_idx_nxt;
            shreg      <= shreg_nxt;
            rd_pend    <= rd_pend_nxt;
            frame_done <= rd_complete;
        end
    end

    assign bit_valid = (rd_state == R_SHIFT);
    assign bit_out   = bit_valid && shreg[0];
    assign sof       = bit_valid && (rd_word == '0) && (bit_idx == '0);
    assign eof       = bit_valid && (rd_word == LAST_WORD) && (bit_idx == LAST_BIT);
    assign is_parity = (rd_word >= PARITY_START);

endmodule

// File: tb/tb_ldpc_frame_unpacker.sv
// Directed bench for ldpc_frame_unpacker: full frame with early random backpressure,
// overflow during drain, mid-frame reset and a gapped source after reset.
module tb_ldpc_frame_unpacker;
    import ldpc_pkg::*;

    logic                clk = 1'b0;
    logic                rst_n = 1'b0;
    logic                valid_in = 1'b0;
    logic [IN_WIDTH-1:0] data_in = '0;
    logic                bit_ready = 1'b0;
    logic                bit_valid, bit_out, sof, eof, is_parity, frame_done, overflow;

    int n_cmp = 0;
    int n_bad = 0;
    int mon_en = 0;
    int mon_frame = 0;
    int mon_k = 0;
    int done_cnt = 0;
    int ones_cnt = 0;
    logic       prev_stall = 1'b0;
    logic       prev_eof_acc = 1'b0;
    logic [3:0] prev_out = '0;

    ldpc_frame_unpacker dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .valid_in  (valid_in),
        .data_in   (data_in),
        .bit_ready (bit_ready),
        .bit_valid (bit_valid),
        .bit_out   (bit_out),
        .sof       (sof),
        .eof       (eof),
        .is_parity (is_parity),
        .frame_done(frame_done),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Frame 0: word w = w; frame 1: alternating pattern; frame 2: all-ones word 0 then a tagged pattern.
    function automatic logic [17:0] word_val(input int f, input int w);
        logic [31:0] wv;
        wv = w;
        case (f)
            0:       return wv[17:0];
            1:       return 18'h2AAAA ^ wv[17:0];
            default: return (w == 0) ? 18'h3FFFF : {wv[5:0], 12'hA5C};
        endcase
    endfunction

    function automatic logic exp_bit(input int f, input int k);
        logic [17:0] v;
        v = word_val(f, k / 18);
        return v[k % 18];
    endfunction

    // Bit-level scoreboard and handshake checks, sampled on the falling edge.
    always @(negedge clk) begin
        if (mon_en != 0) begin
            if (prev_stall) begin
                check("stall_valid", bit_valid, 1);
                check("stall_hold", {bit_out, sof, eof, is_parity}, prev_out);
            end
            check("frame_done", frame_done, prev_eof_acc);
            if (frame_done) done_cnt++;
            if (bit_valid) begin
                check("bit_out", bit_out, exp_bit(mon_frame, mon_k));
                check("sof", sof, (mon_k == 0));
                check("eof", eof, (mon_k == FRAME_WORDS * 18 - 1));
                check("is_parity", is_parity, ((mon_k / 18) >= INFO_WORDS));
                if (bit_ready) begin
                    if (bit_out) ones_cnt++;
                    mon_k++;
                end
            end
            prev_stall   = bit_valid && !bit_ready;
            prev_out     = {bit_out, sof, eof, is_parity};
            prev_eof_acc = bit_valid && bit_ready && eof;
        end else begin
            prev_stall   = 1'b0;
            prev_eof_acc = 1'b0;
        end
    end

    initial begin
        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_bit_valid", bit_valid, 0);
        check("rst_bit_out", bit_out, 0);
        check("rst_sof", sof, 0);
        check("rst_eof", eof, 0);
        check("rst_is_parity", is_parity, 0);
        check("rst_frame_done", frame_done, 0);
        check("rst_overflow", overflow, 0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        // Frame A: 3605 back-to-back words, tag bit set, random ready for the first bits
        mon_frame = 0;
        mon_k     = 0;
        mon_en    = 1;
        for (int w = 0; w < 3605; w++) begin
            @(posedge clk);
            #1;
            valid_in  = 1'b1;
            data_in   = {1'b1, word_val(0, w)};
            bit_ready = (w < 400) ? 1'($urandom_range(0, 1)) : 1'b1;
            if (w < 4) begin
                @(negedge clk);
                check("latency_bit_valid", bit_valid, (w == 3));
            end
        end
        @(posedge clk);
        #1;
        valid_in  = 1'b0;
        data_in   = '0;
        bit_ready = 1'b1;
        @(negedge clk);
        check("hold_no_overflow", overflow, 0);

        // Second frame while frame A is still draining
        repeat (10) @(posedge clk);
        for (int w = 0; w < 20; w++) begin
            @(posedge clk);
            #1;
            valid_in = 1'b1;
            data_in  = {1'b0, word_val(1, w)};
        end
        @(posedge clk);
        #1;
        valid_in = 1'b0;
        data_in  = '0;
        @(negedge clk);
        check("overflow_set", overflow, 1);

        for (int c = 0; c < 80000 && done_cnt == 0; c++) @(negedge clk);
        repeat (2) @(negedge clk);
        check("frame_a_done_cnt", done_cnt, 1);
        check("frame_a_bits", mon_k, FRAME_WORDS * 18);
        check("overflow_sticky", overflow, 1);
        repeat (40) @(negedge clk);
        check("no_restart_valid", bit_valid, 0);
        check("no_restart_done", done_cnt, 1);

        // Frame B: 2000 words then reset mid-frame
        mon_frame = 1;
        mon_k     = 0;
        for (int w = 0; w < 2000; w++) begin
            @(posedge clk);
            #1;
            valid_in = 1'b1;
            data_in  = {1'b0, word_val(1, w)};
        end
        @(posedge clk);
        #1;
        mon_en   = 0;
        rst_n    = 1'b0;
        valid_in = 1'b0;
        data_in  = '0;
        check("frame_b_progress", (mon_k >= 1800), 1);
        @(negedge clk);
        check("mid_rst_bit_valid", bit_valid, 0);
        check("mid_rst_bit_out", bit_out, 0);
        check("mid_rst_sof", sof, 0);
        check("mid_rst_eof", eof, 0);
        check("mid_rst_is_parity", is_parity, 0);
        check("mid_rst_frame_done", frame_done, 0);
        check("mid_rst_overflow", overflow, 0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        // Frame C: all-ones word 0, source gap, then words with a gap every 7 words
        mon_frame = 2;
        mon_k     = 0;
        ones_cnt  = 0;
        mon_en    = 1;
        @(posedge clk);
        #1;
        valid_in = 1'b1;
        data_in  = {1'b1, word_val(2, 0)};
        @(posedge clk);
        #1;
        valid_in = 1'b0;
        data_in  = '0;
        repeat (30) @(negedge clk);
        check("underrun_valid", bit_valid, 0);
        check("word0_bits", mon_k, 18);
        check("word0_ones", ones_cnt, 18);
        for (int w = 1; w < 14; w++) begin
            @(posedge clk);
            #1;
            valid_in = 1'b1;
            data_in  = {1'b1, word_val(2, w)};
            if ((w % 7) == 0) begin
                @(posedge clk);
                #1;
                valid_in = 1'b0;
            end
        end
        @(posedge clk);
        #1;
        valid_in = 1'b0;
        data_in  = '0;
        for (int c = 0; c < 400 && mon_k < 14 * 18; c++) @(negedge clk);
        repeat (2) @(negedge clk);
        check("gap_frame_bits", mon_k, 14 * 18);
        check("gap_drained_valid", bit_valid, 0);
        check("gap_overflow", overflow, 0);
        check("gap_done_cnt", done_cnt, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/ldpc_frame_unpacker.md
# ldpc_frame_unpacker

Receives the 18-bit-per-word LDPC codeword stream produced by the parallel encoder and rebuilds the 64800-bit normal FEC frame as a flow-controlled bit-serial stream for the downstream bit interleaver / mapper. Each frame is 1440 information words followed by 2160 parity words. The frame is buffered in a single word RAM so the one-word-per-cycle burst from the encoder is decoupled from the one-bit-per-cycle, backpressured output. Serialised bits are tagged with start-of-frame, end-of-frame and info/parity markers.

## Interface
- WORD_WIDTH, 18, payload bits per input word
- IN_WIDTH, 19, input bus width (bit 18 carries no payload)
- INFO_WORDS, 1440, information words per frame
- PARITY_WORDS, 2160, parity words per frame
- ADDR_WIDTH, 12, buffer address width (FRAME_WORDS = INFO_WORDS + PARITY_WORDS = 3600)
- clk  in  1  single clock
- rst_n  in  1  asynchronous, active-low reset
- valid_in  in  1  input word valid; no backpressure toward the source
- data_in  in  IN_WIDTH  codeword word; bits [17:0] are frame bits 18w..18w+17, LSB first
- bit_ready  in  1  downstream accepts bit_out this cycle
- bit_valid  out  1  bit_out holds a frame bit
- bit_out  out  1  serial frame bit
- sof  out  1  qualifies bit 0 of the frame
- eof  out  1  qualifies bit 64799 of the frame
- is_parity  out  1  current bit belongs to word index ≥ INFO_WORDS
- frame_done  out  1  one-cycle pulse when the eof bit is accepted
- overflow  out  1  sticky; set when words arrive while the buffer is still draining; cleared only by reset

## Operation
- Write FSM: W_IDLE → W_FILL → W_HOLD → W_WAIT → W_IDLE.
  - W_IDLE: the first valid_in writes word 0 and enters W_FILL.
  - W_FILL: every valid_in cycle writes data_in[17:0] at wr_cnt, then increments wr_cnt. Gaps in valid_in are allowed. The write of word FRAME_WORDS-1 enters W_HOLD.
  - W_HOLD: valid_in remains high after the frame ends. All words seen here are discarded, and overflow is not set. The FSM leaves W_HOLD on the first cycle with valid_in=0.
  - W_WAIT: waits for the read side to finish. If valid_in=1 in this state, set overflow, drop the word, and return to W_HOLD (the whole new frame is discarded).
  - When the read side completes, wr_cnt clears and the FSM returns to W_IDLE. If read completion and valid_in=1 coincide in W_WAIT, the read completion wins: the FSM goes to W_IDLE and the word is dropped with overflow set.
- Read FSM: R_IDLE → R_FETCH → R_SHIFT.
  - R_FETCH: issue a read for rd_word whenever rd_word < wr_cnt. One cycle later, load the 18-bit shift register.
  - R_SHIFT: present shreg[0] with bit_valid=1, held stable until bit_ready. On acceptance, shift right and increment the bit index.
  - After bit 17 is accepted, increment rd_word. Go to R_FETCH, or to R_IDLE after word FRAME_WORDS-1 (pulse frame_done and signal completion to the write FSM).
- The write side is always at least as fast as the read side, so the read never overtakes the write. Underrun occurs only when the source has a gap; bit_valid=0 during the gap.
- data_in[18] is ignored and never stored.

## Timing
- Reset: bit_valid, bit_out, sof, eof, is_parity, frame_done and overflow are 0; both FSMs are idle; counters are 0.
- Latency: first valid_in at cycle T gives bit_valid=1 with frame bit 0 at T+3 (RAM write at T, read issue at T+1, data at T+2, shreg load visible at T+3).
- Each word costs 18 output cycles plus 1 refetch bubble between words.
- sof and eof are asserted only while bit_valid=1 and held with the bit under backpressure. is_parity changes only on word boundaries.
- bit_ready while bit_valid=0 has no effect.
- Reset mid-frame clears everything. The buffer content is left stale but unreachable, and the next valid_in starts a fresh frame at word 0.

## Structure
- Shared package ldpc_pkg: INFO_WORDS, PARITY_WORDS, FRAME_WORDS, WORD_WIDTH (also used by the encoder); write/read state encodings.
- One sub-module: the existing ram_1r1w (DATA_WIDTH=WORD_WIDTH, ADDR_WIDTH=12, DEPTH=FRAME_WORDS) as the frame buffer, with registered read and 1-cycle latency. Both FSMs stay in the top module.

## Test plan
- Full frame, word w = w[17:0], bit_ready=1 → 64800 bits match the word pattern LSB-first. sof on bit 0, eof on bit 64799, is_parity rises at bit 25920, one frame_done pulse.
- Random bit_ready (50%) on the same frame → identical bit sequence; bit_out/sof/eof stable while stalled.
- valid_in held high for 3605 words, data_in[18]=1 → extra 5 words ignored, bit 18 never appears, overflow=0.
- Second frame sent 10 cycles after the first ends (buffer still draining) → overflow=1, first frame output intact, second frame discarded, third frame (after drain) output correctly.
- valid_in with 1-cycle gaps every 7 words → correct output; bit_valid drops only when the reader catches up.
- Reset asserted at word 2000 → all outputs 0. A new frame starting with word 0 = 18'h3FFFF gives eighteen 1s with sof on the first.
